// File: rtl/scan_data_collector.sv
// Collects data bursts from two scanners into a shared tagged FIFO and locks onto one burst at a time.
// Optional per-burst checksum built when SCAN_COLLECTOR_CKSUM_EN is defined; otherwise cksum reads 0.
module scan_data_collector #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s1_valid,
  input  logic [DATA_W-1:0] s1_data,
  input  logic              s1_last,
  output logic              s1_ready,
  input  logic              s2_valid,
  input  logic [DATA_W-1:0] s2_data,
  input  logic              s2_last,
  output logic              s2_ready,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_src,
  output logic              rd_last,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   level,
  output logic              busy,
  output logic              burst_done,
  output logic [7:0]        cksum
);

  localparam int unsigned LVL_W = ADDR_W + 1;

  typedef enum logic [1:0] {ARB, LOCK1, LOCK2} state_e;

  typedef struct packed {
    logic              src;
    logic              last;
    logic [DATA_W-1:0] data;
  } entry_t;

  state_e            state_q, state_d;
  logic              prio_q, prio_d;
  logic              busy_q;
  logic              done_q;
  logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]  level_q, level_d;
  entry_t            mem_q [DEPTH];
  entry_t            head;
  entry_t            wr_entry;
  logic              wr_en, rd_fire;

  // Readies are decoded from the registered lock state and registered level.
  assign full     = (level_q == LVL_W'(DEPTH));
  assign empty    = (level_q == '0);
  assign s1_ready = (state_q == LOCK1) && !full;
  assign s2_ready = (state_q == LOCK2) && !full;

  assign wr_en         = (s1_valid && s1_ready) || (s2_valid && s2_ready);
  assign wr_entry.src  = (state_q == LOCK2);
  assign wr_entry.last = (state_q == LOCK2) ? s2_last : s1_last;
  assign wr_entry.data = (state_q == LOCK2) ? s2_data : s1_data;
  assign rd_fire       = rd_en && !empty;

  assign head       = mem_q[rd_ptr_q];
  assign rd_data    = head.data;
  assign rd_src     = head.src;
  assign rd_last    = head.last;
  assign level      = level_q;
  assign busy       = busy_q;
  assign burst_done = done_q;

  // Arbitration and burst lock; a last beat hands priority to the other scanner.
  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    unique case (state_q)
      ARB: begin
        if (s1_valid && s2_valid) state_d = prio_q ? LOCK2 : LOCK1;
        else if (s1_valid)        state_d = LOCK1;
        else if (s2_valid)        state_d = LOCK2;
      end
      LOCK1, LOCK2: begin
        if (wr_en && wr_entry.last) begin
          state_d = ARB;
          prio_d  = (state_q == LOCK1);
        end
      end
      default: state_d = ARB;
    endcase
  end

  always_comb begin
    level_d = level_q;
    unique case ({wr_en, rd_fire})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ARB;
      prio_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      busy_q  <= (state_d != ARB);
      done_q  <= wr_en && wr_entry.last;
      level_q <= level_d;
      if (wr_en) begin
        mem_q[wr_ptr_q] <= wr_entry;
        wr_ptr_q        <= wr_ptr_q + ADDR_W'(1);
      end
      if (rd_fire) rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
    end
  end

`ifdef SCAN_COLLECTOR_CKSUM_EN
  logic [7:0] sum_q, sum_d;
  logic [7:0] cksum_q, cksum_d;

  // Running sum restarts when a new lock is taken; cksum captures it on the last beat.
  always_comb begin
    sum_d   = sum_q;
    cksum_d = cksum_q;
    if (state_q == ARB && state_d != ARB) sum_d = '0;
    else if (wr_en)                       sum_d = sum_q + 8'(wr_entry.data);
    if (wr_en && wr_entry.last)           cksum_d = sum_q + 8'(wr_entry.data);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sum_q   <= '0;
      cksum_q <= '0;
    end else begin
      sum_q   <= sum_d;
      cksum_q <= cksum_d;
    end
  end

  assign cksum = cksum_q;
`else
  assign cksum = '0;
`endif

endmodule

// File: tb/tb_scan_data_collector.sv
// Bench for scan_data_collector: queue-based reference model checked every cycle plus directed literal checks.
module tb_scan_data_collector;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned ADDR_W = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              s1_valid = 1'b0, s1_last = 1'b0, s2_valid = 1'b0, s2_last = 1'b0;
  logic [DATA_W-1:0] s1_data = '0, s2_data = '0;
  logic              s1_ready, s2_ready;
  logic              rd_en = 1'b0;
  logic [DATA_W-1:0] rd_data;
  logic              rd_src, rd_last, empty, full, busy, burst_done;
  logic [ADDR_W:0]   level;
  logic [7:0]        cksum;

  int vectors = 0;
  int miscompares = 0;

  always #10 clk = ~clk;

  scan_data_collector #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset),
    .s1_valid(s1_valid), .s1_data(s1_data), .s1_last(s1_last), .s1_ready(s1_ready),
    .s2_valid(s2_valid), .s2_data(s2_data), .s2_last(s2_last), .s2_ready(s2_ready),
    .rd_en(rd_en), .rd_data(rd_data), .rd_src(rd_src), .rd_last(rd_last),
    .empty(empty), .full(full), .level(level), .busy(busy),
    .burst_done(burst_done), .cksum(cksum)
  );

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of accepted entries and the scanner currently owning the lock.
  typedef struct packed {
    logic       src;
    logic       last;
    logic [7:0] data;
  } ent_t;

  ent_t       mq[$];
  int         owner = 0;
  bit         m_prio = 1'b0;
  bit         m_done = 1'b0;
  logic [7:0] m_sum = '0;
  logic [7:0] m_ck = '0;

  always @(posedge clk or negedge reset) begin
    bit   acc;
    ent_t e;
    if (!reset) begin
      mq.delete();
      owner  = 0;
      m_prio = 1'b0;
      m_done = 1'b0;
      m_sum  = '0;
      m_ck   = '0;
    end else begin
      acc = (mq.size() < DEPTH) &&
            ((owner == 1 && s1_valid) || (owner == 2 && s2_valid));
      if (rd_en && mq.size() > 0) void'(mq.pop_front());
      m_done = 1'b0;
      if (acc) begin
        e.src  = (owner == 2);
        e.data = (owner == 2) ? s2_data : s1_data;
        e.last = (owner == 2) ? s2_last : s1_last;
        mq.push_back(e);
        m_sum = m_sum + e.data;
        if (e.last) begin
          m_ck   = m_sum;
          m_done = 1'b1;
          m_prio = (owner == 1);
          owner  = 0;
        end
      end else if (owner == 0) begin
        if (s1_valid && s2_valid) owner = m_prio ? 2 : 1;
        else if (s1_valid)        owner = 1;
        else if (s2_valid)        owner = 2;
        if (owner != 0) m_sum = '0;
      end
    end
  end

  always @(negedge clk) begin
    int sz;
    sz = mq.size();
    chk("s1_ready", s1_ready, (owner == 1 && sz < DEPTH));
    chk("s2_ready", s2_ready, (owner == 2 && sz < DEPTH));
    chk("level", level, sz);
    chk("empty", empty, (sz == 0));
    chk("full", full, (sz == DEPTH));
    chk("busy", busy, (owner != 0));
    chk("burst_done", burst_done, m_done);
`ifdef SCAN_COLLECTOR_CKSUM_EN
    chk("cksum", cksum, m_ck);
`else
    chk("cksum", cksum, 0);
`endif
    if (sz > 0) begin
      chk("rd_data", rd_data, mq[0].data);
      chk("rd_src", rd_src, mq[0].src);
      chk("rd_last", rd_last, mq[0].last);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int src, input logic v, input logic [7:0] d, input logic l);
    if (src == 1) begin
      s1_valid = v; s1_data = d; s1_last = l;
    end else begin
      s2_valid = v; s2_data = d; s2_last = l;
    end
  endtask

  // Sends n beats base, base+step, ... holding valid until each is accepted.
  task automatic send(input int src, input int n, input int base, input int step);
    int k = 0;
    int guard = 0;
    while (k < n && guard < 200) begin
      drive(src, 1'b1, 8'(base + k * step), (k == n - 1));
      if ((src == 1) ? s1_ready : s2_ready) k++;
      tick();
      guard++;
    end
    drive(src, 1'b0, 8'h00, 1'b0);
    if (k < n) chk("send_timeout", k, n);
  endtask

  task automatic drain();
    int g = 0;
    rd_en = 1'b1;
    while (!empty && g < 100) begin
      tick();
      g++;
    end
    rd_en = 1'b0;
    chk("drain_empty", empty, 1);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    int k;
    tick();
    tick();
    // Reset values
    chk("rst_level", level, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_busy", busy, 0);
    chk("rst_s1_ready", s1_ready, 0);
    chk("rst_s2_ready", s2_ready, 0);
    chk("rst_burst_done", burst_done, 0);
    chk("rst_cksum", cksum, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_rd_src", rd_src, 0);
    chk("rst_rd_last", rd_last, 0);
    reset = 1'b1;
    tick();

    // Single burst 0x11,0x22,0x33 from scanner 1
    drive(1, 1'b1, 8'h11, 1'b0);
    chk("t1_ready_arb", s1_ready, 0);
    tick();
    chk("t1_ready_lock", s1_ready, 1);
    send(1, 3, 8'h11, 8'h11);
    chk("t1_level", level, 3);
    chk("t1_done", burst_done, 1);
    chk("t1_busy", busy, 0);
`ifdef SCAN_COLLECTOR_CKSUM_EN
    chk("t1_cksum", cksum, 8'h66);
`else
    chk("t1_cksum", cksum, 0);
`endif
    tick();
    chk("t1_done_clear", burst_done, 0);
    for (int i = 0; i < 3; i++) begin
      chk("t1_rd_data", rd_data, 8'h11 * (i + 1));
      chk("t1_rd_src", rd_src, 0);
      chk("t1_rd_last", rd_last, (i == 2));
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
    end
    chk("t1_empty", empty, 1);

    // Contention from reset: scanner 1 first, then scanner 2
    do_reset();
    fork
      send(1, 2, 8'hA0, 1);
      send(2, 2, 8'hB0, 1);
    join
    tick();
    chk("t2_level", level, 4);
    for (int i = 0; i < 4; i++) begin
      chk("t2_order_data", rd_data, (i < 2) ? (8'hA0 + i) : (8'hB0 + i - 2));
      chk("t2_order_src", rd_src, (i >= 2));
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
    end

    // Full back-pressure: scanner 2 streams 20 beats
    do_reset();
    k = 0;
    for (int g = 0; g < 60 && k < 16; g++) begin
      drive(2, 1'b1, 8'(k), 1'b0);
      if (s2_ready) k++;
      tick();
    end
    chk("t3_full", full, 1);
    chk("t3_level16", level, 16);
    chk("t3_ready_low", s2_ready, 0);
    tick();
    chk("t3_ready_still_low", s2_ready, 0);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk("t3_ready_after_pop", s2_ready, 1);
    chk("t3_full_after_pop", full, 0);
    chk("t3_level15", level, 15);
    tick();
    k = 17;
    chk("t3_level_back16", level, 16);
    chk("t3_full_again", full, 1);
    rd_en = 1'b1;
    for (int g = 0; g < 100 && k < 20; g++) begin
      drive(2, 1'b1, 8'(k), (k == 19));
      if (s2_ready) k++;
      tick();
    end
    drive(2, 1'b0, 8'h00, 1'b0);
    chk("t3_all_sent", k, 20);
    drain();

    // Concurrent read/write at level 5, across the pointer wrap
    send(1, 8, 8'h40, 1);
    drain();
    send(1, 5, 8'h50, 1);
    chk("t4_level5", level, 5);
    drive(1, 1'b1, 8'h60, 1'b0);
    tick();
    chk("t4_lock", s1_ready, 1);
    rd_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1, 1'b1, 8'(8'h60 + i), (i == 3));
      chk("t4_ready", s1_ready, 1);
      tick();
      chk("t4_level_hold", level, 5);
    end
    rd_en = 1'b0;
    drive(1, 1'b0, 8'h00, 1'b0);
    chk("t4_head", rd_data, 8'h54);
    drain();

    // Reset in the middle of a burst, then scanner 2 is granted
    drive(1, 1'b1, 8'h70, 1'b0);
    tick();
    for (int i = 0; i < 2; i++) begin
      drive(1, 1'b1, 8'(8'h70 + i), 1'b0);
      tick();
    end
    chk("t5_level_pre", level, 2);
    reset = 1'b0;
    #1;
    chk("t5_empty", empty, 1);
    chk("t5_level", level, 0);
    chk("t5_busy", busy, 0);
    chk("t5_s1_ready", s1_ready, 0);
    chk("t5_s2_ready", s2_ready, 0);
    drive(1, 1'b0, 8'h00, 1'b0);
    tick();
    reset = 1'b1;
    drive(2, 1'b1, 8'h99, 1'b1);
    chk("t5_s2_arb", s2_ready, 0);
    tick();
    chk("t5_s2_grant", s2_ready, 1);
    tick();
    drive(2, 1'b0, 8'h00, 1'b0);
    chk("t5_rd_data", rd_data, 8'h99);
    chk("t5_rd_src", rd_src, 1);
    chk("t5_rd_last", rd_last, 1);
    chk("t5_level1", level, 1);
    drain();

    // Reads while empty are ignored
    rd_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t6_level0", level, 0);
      chk("t6_empty", empty, 1);
    end
    rd_en = 1'b0;
    send(1, 1, 8'h5A, 0);
    chk("t6_rd_data", rd_data, 8'h5A);
    chk("t6_rd_src", rd_src, 0);
    chk("t6_rd_last", rd_last, 1);
    chk("t6_level1", level, 1);
    drain();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
